gray_bin_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with valid/ready handshaking on both sides. Each transaction selects its direction: Gray-to-binary or binary-to-Gray. The Gray-to-binary prefix-XOR chain is split across `STAGES` register stages so wide words meet timing. It sits between pointer/encoder sources and consumers, for example CDC pointer decode or rotary-encoder position decode, and absorbs back-pressure without dropping or duplicating words.

---
 rtl/gray_bin_pipe_pkg.sv | 12 +
 rtl/gray_bin_pipe_if.sv | 23 ++
 rtl/gray_bin_stage.sv | 75 +++++++
 rtl/gray_bin_pipe.sv | 74 +++++++
 tb/tb_gray_bin_pipe.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_bin_pipe_pkg.sv
// rtl/gray_bin_pipe_pkg.sv - shared mode constants and chunk-size helper for Gray converters
package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Ceil division: bits resolved per pipeline stage.
    function automatic int chunk_f(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/gray_bin_pipe_if.sv
// rtl/gray_bin_pipe_if.sv - input/output handshake bundle for the Gray/binary converter
interface gray_bin_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/gray_bin_stage.sv
// rtl/gray_bin_stage.sv - one pipeline stage: resolves Gray bits [HI:LO] and registers the word
module gray_bin_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
);
    localparam bit FIRST = (HI == WIDTH - 1);

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] resolved;
    logic             load;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             mode_d, mode_q;

    // Zero pad above the MSB is the carry-in for the first stage; later stages
    // read the bit just above HI, already resolved upstream.
    always_comb begin
        ext = {1'b0, in_data};
        if (FIRST && in_mode == MODE_B2G) begin
            ext = {1'b0, in_data ^ (in_data >> 1)};
        end else if (in_mode == MODE_G2B) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    ext[i] = ext[i+1] ^ ext[i];
                end
            end
        end
        resolved = ext[WIDTH-1:0];
    end

    assign load = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = resolved;
                mode_d = in_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/gray_bin_pipe.sv
// rtl/gray_bin_pipe.sv - pipelined Gray<->binary converter with valid/ready on both sides
module gray_bin_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_bin_pipe_if.slave bus
);
    localparam int CHUNK = chunk_f(WIDTH, STAGES);

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_mode;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES:0]   stage_ready;

    // Stage s may load when any stage from s onward is empty or the output drains;
    // written out flat so the ready chain has no self-referencing vector.
    always_comb begin
        stage_ready         = '0;
        stage_ready[STAGES] = bus.out_ready;
        for (int s = 0; s < STAGES; s++) begin
            stage_ready[s] = bus.out_ready;
            for (int k = s; k < STAGES; k++) begin
                if (!stage_valid[k]) begin
                    stage_ready[s] = 1'b1;
                end
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int HI = WIDTH - 1 - s * CHUNK;
        localparam int LO = (WIDTH - (s + 1) * CHUNK > 0) ? WIDTH - (s + 1) * CHUNK : 0;

        logic             in_valid_s;
        logic [WIDTH-1:0] in_data_s;
        logic             in_mode_s;

        if (s == 0) begin : g_head
            assign in_valid_s = bus.in_valid;
            assign in_data_s  = bus.in_data;
            assign in_mode_s  = bus.in_mode;
        end else begin : g_body
            assign in_valid_s = stage_valid[s-1];
            assign in_data_s  = stage_data[s-1];
            assign in_mode_s  = stage_mode[s-1];
        end

        gray_bin_stage #(
            .WIDTH (WIDTH),
            .HI    (HI),
            .LO    (LO)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s),
            .in_data   (in_data_s),
            .in_mode   (in_mode_s),
            .out_ready (stage_ready[s+1]),
            .out_valid (stage_valid[s]),
            .out_data  (stage_data[s]),
            .out_mode  (stage_mode[s])
        );
    end

    assign bus.in_ready  = stage_ready[0];
    assign bus.out_valid = stage_valid[STAGES-1];
    assign bus.out_data  = stage_data[STAGES-1];
    assign bus.out_mode  = stage_mode[STAGES-1];

endmodule

// File: tb/tb_gray_bin_pipe.sv
// tb/tb_gray_bin_pipe.sv - directed and table-driven checks of gray_bin_pipe across parameter corners
module tb_gray_bin_pipe;
    import gray_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_bin_pipe_if #(.WIDTH(8)) if82 ();
    gray_bin_pipe_if #(.WIDTH(8)) if81 ();
    gray_bin_pipe_if #(.WIDTH(5)) if55 ();
    gray_bin_pipe_if #(.WIDTH(7)) if73 ();

    gray_bin_pipe #(.WIDTH(8), .STAGES(2)) u82 (.clk(clk), .rst_n(rst_n), .bus(if82.slave));
    gray_bin_pipe #(.WIDTH(8), .STAGES(1)) u81 (.clk(clk), .rst_n(rst_n), .bus(if81.slave));
    gray_bin_pipe #(.WIDTH(5), .STAGES(5)) u55 (.clk(clk), .rst_n(rst_n), .bus(if55.slave));
    gray_bin_pipe #(.WIDTH(7), .STAGES(3)) u73 (.clk(clk), .rst_n(rst_n), .bus(if73.slave));

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [7:0] dout;
    } vec_t;

    int passed = 0;
    int total  = 0;

    vec_t       vec [4];
    logic [8:0] q [$];
    logic [8:0] exp_w;
    logic [7:0] bp_d [4];
    logic       bp_m [4];
    logic [7:0] x;
    logic       m;
    int         lat, rx, stalls, acc, first_c, last_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [7:0] g2b_m(input logic [7:0] g, input int w);
        logic [7:0] b;
        b = '0;
        b[w-1] = g[w-1];
        for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [7:0] model(input logic [7:0] v, input logic md, input int w);
        return md ? (v ^ (v >> 1)) : g2b_m(v, w);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        if82.in_valid = 0; if82.in_data = '0; if82.in_mode = 0; if82.out_ready = 0;
        if81.in_valid = 0; if81.in_data = '0; if81.in_mode = 0; if81.out_ready = 0;
        if55.in_valid = 0; if55.in_data = '0; if55.in_mode = 0; if55.out_ready = 0;
        if73.in_valid = 0; if73.in_data = '0; if73.in_mode = 0; if73.out_ready = 0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", if82.out_valid, 0);
        check("rst_out_data", if82.out_data, 0);
        check("rst_out_mode", if82.out_mode, 0);
        check("rst_in_ready", if82.in_ready, 1);
        rst_n = 1'b1;

        // Directed table on the default 8/2 configuration
        vec[0] = '{8'hC3, 1'b0, 8'h82};
        vec[1] = '{8'hFF, 1'b1, 8'h80};
        vec[2] = '{8'h80, 1'b0, 8'hFF};
        vec[3] = '{8'h5A, 1'b1, 8'h77};
        if82.out_ready = 1;
        for (int v = 0; v < 4; v++) begin
            if82.in_valid = 1; if82.in_data = vec[v].din; if82.in_mode = vec[v].mode;
            #1 check("dir_in_ready", if82.in_ready, 1);
            @(posedge clk); lat = 1;
            @(negedge clk); if82.in_valid = 0;
            while (!if82.out_valid && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
            check("dir_latency", lat, 2);
            check("dir_data", if82.out_data, vec[v].dout);
            check("dir_mode", if82.out_mode, vec[v].mode);
        end
        @(posedge clk); @(negedge clk);
        check("drain_empty", if82.out_valid, 0);

        // Exhaustive back-to-back stream with alternating modes
        q.delete(); rx = 0; stalls = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 260; c++) begin
            if (if82.out_valid) begin
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                    check("rt_word", {if82.out_mode, if82.out_data}, exp_w);
                end else begin
                    check("rt_extra_word", 1, 0);
                end
                rx++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (c < 256) begin
                x = c[7:0]; m = c[0];
                if82.in_valid = 1; if82.in_data = x; if82.in_mode = m;
                q.push_back({m, model(x, m, 8)});
                #1 if (!if82.in_ready) stalls++;
            end else begin
                if82.in_valid = 0;
            end
            @(negedge clk);
        end
        check("rt_count", rx, 256);
        check("rt_stalls", stalls, 0);
        check("rt_contiguous", last_c - first_c, 255);

        // Back-pressure: capacity is STAGES words, output held while stalled
        bp_d[0] = 8'h11; bp_m[0] = 0;
        bp_d[1] = 8'h22; bp_m[1] = 1;
        bp_d[2] = 8'h33; bp_m[2] = 0;
        bp_d[3] = 8'h44; bp_m[3] = 1;
        q.delete(); acc = 0;
        if82.out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            if82.in_valid = 1; if82.in_data = bp_d[acc]; if82.in_mode = bp_m[acc];
            #1 if (if82.in_ready) begin q.push_back({bp_m[acc], model(bp_d[acc], bp_m[acc], 8)}); acc++; end
            @(negedge clk);
        end
        check("bp_accepted", acc, 2);
        #1 check("bp_in_ready_low", if82.in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_valid", if82.out_valid, 1);
            check("bp_hold_data", {if82.out_mode, if82.out_data}, {1'b0, 8'h1E});
            @(negedge clk);
        end
        if82.out_ready = 1; rx = 0;
        for (int c = 0; c < 20 && rx < 4; c++) begin
            if (if82.out_valid) begin
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                    check("bp_word", {if82.out_mode, if82.out_data}, exp_w);
                end else begin
                    check("bp_extra_word", 1, 0);
                end
                rx++;
            end
            if (acc < 4) begin
                if82.in_valid = 1; if82.in_data = bp_d[acc]; if82.in_mode = bp_m[acc];
                #1 if (if82.in_ready) begin q.push_back({bp_m[acc], model(bp_d[acc], bp_m[acc], 8)}); acc++; end
            end else begin
                if82.in_valid = 0;
            end
            @(negedge clk);
        end
        if82.in_valid = 0;
        check("bp_rx_count", rx, 4);
        check("bp_all_fed", acc, 4);
        check("bp_queue_empty", q.size(), 0);

        // Asynchronous reset with two words in flight
        repeat (2) @(negedge clk);
        if82.out_ready = 0;
        if82.in_valid = 1; if82.in_data = 8'hFF; if82.in_mode = 1;
        @(negedge clk);
        if82.in_data = 8'h0F; if82.in_mode = 0;
        @(negedge clk);
        if82.in_valid = 0;
        check("pre_rst_word", {if82.out_valid, if82.out_mode, if82.out_data}, {1'b1, 1'b1, 8'h80});
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", if82.out_valid, 0);
        check("mid_rst_out_data", if82.out_data, 0);
        check("mid_rst_out_mode", if82.out_mode, 0);
        check("mid_rst_in_ready", if82.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1; if82.out_ready = 1;
        if82.in_valid = 1; if82.in_data = 8'h01; if82.in_mode = 0;
        @(posedge clk); lat = 1;
        @(negedge clk); if82.in_valid = 0;
        while (!if82.out_valid && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
        check("post_rst_latency", lat, 2);
        check("post_rst_word", {if82.out_mode, if82.out_data}, {1'b0, 8'h01});

        // STAGES=1: single-cycle latency
        if81.out_ready = 1;
        if81.in_valid = 1; if81.in_data = 8'hC3; if81.in_mode = 0;
        @(posedge clk); lat = 1;
        @(negedge clk); if81.in_valid = 0;
        while (!if81.out_valid && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
        check("s1_latency", lat, 1);
        check("s1_word", {if81.out_mode, if81.out_data}, {1'b0, 8'h82});

        // WIDTH=5, STAGES=5: one bit per stage
        if55.out_ready = 1;
        if55.in_valid = 1; if55.in_data = 5'b11111; if55.in_mode = 0;
        @(posedge clk); lat = 1;
        @(negedge clk); if55.in_valid = 0;
        while (!if55.out_valid && lat < 12) begin @(posedge clk); lat++; @(negedge clk); end
        check("w5_latency", lat, 5);
        check("w5_g2b", {if55.out_mode, if55.out_data}, {1'b0, 5'b10101});
        if55.in_valid = 1; if55.in_data = 5'b10110; if55.in_mode = 1;
        @(posedge clk); lat = 1;
        @(negedge clk); if55.in_valid = 0;
        while (!(if55.out_valid && if55.out_mode) && lat < 12) begin @(posedge clk); lat++; @(negedge clk); end
        check("w5_b2g_latency", lat, 5);
        check("w5_b2g", {if55.out_mode, if55.out_data}, {1'b1, 5'b11101});

        // WIDTH=7, STAGES=3: uneven chunks, random words
        if73.out_ready = 1; q.delete(); rx = 0;
        for (int c = 0; c < 16; c++) begin
            if (if73.out_valid) begin
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                    check("w7_word", {if73.out_mode, 1'b0, if73.out_data}, exp_w);
                end else begin
                    check("w7_extra_word", 1, 0);
                end
                rx++;
            end
            if (c < 12) begin
                x = 8'($urandom_range(0, 127)); m = (c % 4 == 3);
                if73.in_valid = 1; if73.in_data = x[6:0]; if73.in_mode = m;
                q.push_back({m, model(x, m, 7)});
            end else begin
                if73.in_valid = 0;
            end
            @(negedge clk);
        end
        check("w7_count", rx, 12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
